// File: rtl/otp_i2c_pkg.sv
// rtl/otp_i2c_pkg.sv - shared types and constants for the OTP unlock/command sequencer
package otp_i2c_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_WAIT,
        ST_GAP,
        ST_DONE,
        ST_ERR
    } state_t;

    localparam logic [7:0] DEF_PASS_BASE = 8'h05;
    localparam logic [7:0] DEF_CMD_REG   = 8'h04;

    // Unlock passcode "PHSGNX", written to PASS_BASE..PASS_BASE+5 in order
    localparam logic [7:0] PASS_CODE [6] = '{8'h50, 8'h48, 8'h53, 8'h47, 8'h4E, 8'h58};

    localparam logic [1:0] ERR_NONE = 2'b00;
    localparam logic [1:0] ERR_NACK = 2'b01;
    localparam logic [1:0] ERR_TMO  = 2'b10;

endpackage

// File: rtl/i2c_otp_sequencer.sv
// rtl/i2c_otp_sequencer.sv - writes the OTP passcode then one command byte through an I2C master
module i2c_otp_sequencer
    import otp_i2c_pkg::*;
#(
    parameter logic [6:0]  DEV_ADDR  = 7'h0A,
    parameter logic [7:0]  PASS_BASE = DEF_PASS_BASE,
    parameter logic [7:0]  CMD_REG   = DEF_CMD_REG,
    parameter int unsigned GAP_CYC   = 16,
    parameter int unsigned MAX_RETRY = 3,
    parameter int unsigned TMO_CYC   = 1023
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic [7:0] op,
    output logic       busy,
    output logic       done,
    output logic       err,
    output logic [1:0] err_code,
    output logic       i2c_req,
    output logic [6:0] i2c_dev,
    output logic [7:0] i2c_reg,
    output logic [7:0] i2c_data,
    input  logic       i2c_done,
    input  logic       i2c_nack
);

    localparam logic [7:0]  GAP_LAST  = 8'(GAP_CYC - 1);
    localparam logic [15:0] TMO_LAST  = 16'(TMO_CYC - 1);
    localparam logic [2:0]  RETRY_LIM = 3'(MAX_RETRY);
    localparam logic [2:0]  LAST_IDX  = 3'd6;

    state_t      state;
    state_t      state_nxt;
    logic [7:0]  op_q;
    logic [2:0]  idx;
    logic [2:0]  retry;
    logic [7:0]  gap_cnt;
    logic [15:0] tmo_cnt;
    logic        nack_lim;
    logic        tmo_hit;
    logic [7:0]  seq_reg;
    logic [7:0]  seq_data;

    assign busy = (state != ST_IDLE);
    assign done = (state == ST_DONE);

    always_comb begin
        seq_reg  = CMD_REG;
        seq_data = op_q;
        if (idx != LAST_IDX) begin
            seq_reg  = PASS_BASE + {5'd0, idx};
            seq_data = PASS_CODE[idx];
        end
        nack_lim = ((retry + 3'd1) >= RETRY_LIM);
        // An engine response in the same cycle wins over the timeout
        tmo_hit  = !i2c_done && (tmo_cnt >= TMO_LAST);
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:  if (start) state_nxt = ST_ISSUE;
            ST_ISSUE: state_nxt = ST_WAIT;
            ST_WAIT: begin
                if (i2c_done) begin
                    if (!i2c_nack)
                        state_nxt = (idx == LAST_IDX) ? ST_DONE : ST_GAP;
                    else
                        state_nxt = nack_lim ? ST_ERR : ST_GAP;
                end else if (tmo_hit) begin
                    state_nxt = ST_ERR;
                end
            end
            ST_GAP:   if (gap_cnt >= GAP_LAST) state_nxt = ST_ISSUE;
            ST_DONE:  state_nxt = ST_IDLE;
            ST_ERR:   state_nxt = ST_IDLE;
            default:  state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= ST_IDLE;
            op_q     <= '0;
            idx      <= '0;
            retry    <= '0;
            gap_cnt  <= '0;
            tmo_cnt  <= '0;
            err      <= 1'b0;
            err_code <= ERR_NONE;
            i2c_req  <= 1'b0;
            i2c_dev  <= '0;
            i2c_reg  <= '0;
            i2c_data <= '0;
        end else begin
            state <= state_nxt;
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        op_q     <= op;
                        idx      <= '0;
                        retry    <= '0;
                        err      <= 1'b0;
                        err_code <= ERR_NONE;
                    end
                end
                ST_ISSUE: begin
                    i2c_req  <= 1'b1;
                    i2c_dev  <= DEV_ADDR;
                    i2c_reg  <= seq_reg;
                    i2c_data <= seq_data;
                    tmo_cnt  <= '0;
                end
                ST_WAIT: begin
                    if (i2c_done) begin
                        i2c_req <= 1'b0;
                        gap_cnt <= '0;
                        if (!i2c_nack) begin
                            retry <= '0;
                            if (idx != LAST_IDX) idx <= idx + 3'd1;
                        end else begin
                            if (retry != 3'd7) retry <= retry + 3'd1;
                            if (nack_lim) begin
                                err      <= 1'b1;
                                err_code <= ERR_NACK;
                            end
                        end
                    end else if (tmo_hit) begin
                        i2c_req  <= 1'b0;
                        err      <= 1'b1;
                        err_code <= ERR_TMO;
                    end else if (tmo_cnt != 16'hFFFF) begin
                        tmo_cnt <= tmo_cnt + 16'd1;
                    end
                end
                ST_GAP: begin
                    if (gap_cnt != 8'hFF) gap_cnt <= gap_cnt + 8'd1;
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_i2c_otp_sequencer.sv
// tb/tb_i2c_otp_sequencer.sv - scoreboard bench for i2c_otp_sequencer with a scripted I2C engine
module tb_i2c_otp_sequencer;

    localparam logic [6:0] DEV      = 7'h0A;
    localparam int         ACK_DLY  = 10;
    // Low cycles before a request: first one sees only the ISSUE cycle,
    // later ones see 16 GAP cycles plus the ISSUE cycle.
    localparam int         LOW_FIRST = 1;
    localparam int         LOW_GAP   = 16 + 1;

    typedef struct {
        logic [7:0] rg;
        logic [7:0] dt;
        int         low;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic [7:0] op;
    logic       busy;
    logic       done;
    logic       err;
    logic [1:0] err_code;
    logic       i2c_req;
    logic [6:0] i2c_dev;
    logic [7:0] i2c_reg;
    logic [7:0] i2c_data;
    logic       i2c_done;
    logic       i2c_nack;

    exp_t exp_q[$];
    bit   nack_q[$];
    bit   eng_mute = 1'b0;
    int   wr_cnt   = 0;
    int   done_cnt = 0;
    int   n_checks = 0;
    int   n_fail   = 0;

    logic       req_prev  = 1'b0;
    logic       busy_prev = 1'b0;
    int         low_cnt   = 0;
    logic [7:0] held_reg  = '0;
    logic [7:0] held_data = '0;

    i2c_otp_sequencer dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .op       (op),
        .busy     (busy),
        .done     (done),
        .err      (err),
        .err_code (err_code),
        .i2c_req  (i2c_req),
        .i2c_dev  (i2c_dev),
        .i2c_reg  (i2c_reg),
        .i2c_data (i2c_data),
        .i2c_done (i2c_done),
        .i2c_nack (i2c_nack)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
        end
    endtask

    task automatic push_std(input logic [7:0] cmd);
        exp_q.push_back('{8'h05, 8'h50, LOW_FIRST});
        exp_q.push_back('{8'h06, 8'h48, LOW_GAP});
        exp_q.push_back('{8'h07, 8'h53, LOW_GAP});
        exp_q.push_back('{8'h08, 8'h47, LOW_GAP});
        exp_q.push_back('{8'h09, 8'h4E, LOW_GAP});
        exp_q.push_back('{8'h0A, 8'h58, LOW_GAP});
        exp_q.push_back('{8'h04, cmd,   LOW_GAP});
    endtask

    task automatic pulse_start(input logic [7:0] v);
        @(negedge clk);
        op    = v;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_idle(input string name, input int budget);
        int n = 0;
        while (busy && n < budget) begin
            @(negedge clk);
            n++;
        end
        chk({name, "_reaches_idle"}, 32'(busy), 32'd0);
    endtask

    task automatic wait_wr(input string name, input int target, input int budget);
        int n = 0;
        while (wr_cnt < target && n < budget) begin
            @(negedge clk);
            n++;
        end
        chk({name, "_write_count_reached"}, 32'(wr_cnt), 32'(target));
    endtask

    task automatic begin_test();
        wr_cnt   = 0;
        done_cnt = 0;
        exp_q.delete();
        nack_q.delete();
    endtask

    // Engine model: acknowledges each request ACK_DLY cycles after it is seen
    initial begin : engine
        bit aborted;
        i2c_done = 1'b0;
        i2c_nack = 1'b0;
        forever begin
            @(negedge clk);
            if (i2c_req && !eng_mute) begin
                aborted = 1'b0;
                for (int k = 0; k < ACK_DLY; k++) begin
                    @(negedge clk);
                    if (!i2c_req) begin
                        aborted = 1'b1;
                        break;
                    end
                end
                if (!aborted) begin
                    if (nack_q.size() > 0) i2c_nack = nack_q.pop_front();
                    else i2c_nack = 1'b0;
                    i2c_done = 1'b1;
                    @(negedge clk);
                    i2c_done = 1'b0;
                    i2c_nack = 1'b0;
                end
            end
        end
    end

    // Monitor: pops one expected write per rising i2c_req
    initial begin : monitor
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (busy && !busy_prev) low_cnt = 1;
            else if (!i2c_req && req_prev) low_cnt = 1;
            else if (!i2c_req) low_cnt++;

            if (i2c_req && !req_prev) begin
                wr_cnt++;
                chk("write_was_expected", 32'(exp_q.size() != 0), 32'd1);
                if (exp_q.size() != 0) begin
                    e = exp_q.pop_front();
                    chk("write_dev",  32'(i2c_dev),  32'(DEV));
                    chk("write_reg",  32'(i2c_reg),  32'(e.rg));
                    chk("write_data", 32'(i2c_data), 32'(e.dt));
                    chk("write_low_cycles_before", 32'(low_cnt), 32'(e.low));
                end
                held_reg  = i2c_reg;
                held_data = i2c_data;
            end else if (i2c_req) begin
                chk("write_held_stable", {16'd0, i2c_reg, i2c_data}, {16'd0, held_reg, held_data});
            end

            if (done) done_cnt++;
            req_prev  = i2c_req;
            busy_prev = busy;
        end
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

    initial begin : stim
        int hi;
        int n;
        rst   = 1'b1;
        start = 1'b0;
        op    = 8'h00;
        repeat (3) @(negedge clk);
        chk("reset_outputs",
            32'({busy, done, err, err_code, i2c_req, i2c_dev, i2c_reg, i2c_data}), 32'd0);
        rst = 1'b0;
        @(negedge clk);

        // Clean run
        begin_test();
        push_std(8'hA5);
        pulse_start(8'hA5);
        wait_idle("clean", 1000);
        chk("clean_writes", 32'(wr_cnt), 32'd7);
        chk("clean_all_writes_seen", 32'(exp_q.size()), 32'd0);
        chk("clean_done_pulses", 32'(done_cnt), 32'd1);
        chk("clean_err", 32'(err), 32'd0);
        chk("clean_err_code", 32'(err_code), 32'd0);

        // Single NACK at idx 3, reissued after a gap
        begin_test();
        nack_q = '{1'b0, 1'b0, 1'b0, 1'b1};
        exp_q.push_back('{8'h05, 8'h50, LOW_FIRST});
        exp_q.push_back('{8'h06, 8'h48, LOW_GAP});
        exp_q.push_back('{8'h07, 8'h53, LOW_GAP});
        exp_q.push_back('{8'h08, 8'h47, LOW_GAP});
        exp_q.push_back('{8'h08, 8'h47, LOW_GAP});
        exp_q.push_back('{8'h09, 8'h4E, LOW_GAP});
        exp_q.push_back('{8'h0A, 8'h58, LOW_GAP});
        exp_q.push_back('{8'h04, 8'h3C, LOW_GAP});
        pulse_start(8'h3C);
        wait_idle("nack1", 1000);
        chk("nack1_writes", 32'(wr_cnt), 32'd8);
        chk("nack1_all_writes_seen", 32'(exp_q.size()), 32'd0);
        chk("nack1_done_pulses", 32'(done_cnt), 32'd1);
        chk("nack1_err", 32'(err), 32'd0);

        // NACK limit on idx 0
        begin_test();
        nack_q = '{1'b1, 1'b1, 1'b1};
        exp_q.push_back('{8'h05, 8'h50, LOW_FIRST});
        exp_q.push_back('{8'h05, 8'h50, LOW_GAP});
        exp_q.push_back('{8'h05, 8'h50, LOW_GAP});
        pulse_start(8'h5A);
        wait_idle("nacklim", 1000);
        chk("nacklim_writes", 32'(wr_cnt), 32'd3);
        chk("nacklim_err", 32'(err), 32'd1);
        chk("nacklim_err_code", 32'(err_code), 32'd1);
        chk("nacklim_done_pulses", 32'(done_cnt), 32'd0);
        chk("nacklim_req", 32'(i2c_req), 32'd0);
        chk("nacklim_busy", 32'(busy), 32'd0);
        repeat (5) @(negedge clk);
        chk("nacklim_err_sticky", 32'({err, err_code}), 32'h5);

        // Timeout: engine never answers
        begin_test();
        eng_mute = 1'b1;
        exp_q.push_back('{8'h05, 8'h50, LOW_FIRST});
        pulse_start(8'h99);
        chk("tmo_err_cleared_by_start", 32'({err, err_code}), 32'd0);
        n = 0;
        while (!i2c_req && n < 10) begin
            @(negedge clk);
            n++;
        end
        hi = 0;
        while (i2c_req && hi < 3000) begin
            @(negedge clk);
            hi++;
        end
        chk("tmo_wait_cycles", 32'(hi), 32'd1023);
        wait_idle("tmo", 20);
        chk("tmo_err_code", 32'(err_code), 32'd2);
        chk("tmo_err", 32'(err), 32'd1);
        chk("tmo_req", 32'(i2c_req), 32'd0);
        chk("tmo_done_pulses", 32'(done_cnt), 32'd0);
        eng_mute = 1'b0;

        // Reset during WAIT of idx 4, then a fresh run
        begin_test();
        push_std(8'h77);
        pulse_start(8'h77);
        wait_wr("rstmid", 5, 1000);
        repeat (2) @(negedge clk);
        chk("rstmid_in_wait_reg", 32'({i2c_req, i2c_reg}), 32'h109);
        rst = 1'b1;
        @(negedge clk);
        chk("rstmid_outputs",
            32'({busy, done, err, err_code, i2c_req, i2c_dev, i2c_reg, i2c_data}), 32'd0);
        rst = 1'b0;
        chk("rstmid_no_done", 32'(done_cnt), 32'd0);
        repeat (4) @(negedge clk);
        begin_test();
        push_std(8'h11);
        pulse_start(8'h11);
        wait_idle("rstmid_rerun", 1000);
        chk("rstmid_rerun_writes", 32'(wr_cnt), 32'd7);
        chk("rstmid_rerun_all_seen", 32'(exp_q.size()), 32'd0);
        chk("rstmid_rerun_done", 32'(done_cnt), 32'd1);

        // Extra start pulses while busy in GAP
        begin_test();
        push_std(8'hC3);
        pulse_start(8'hC3);
        wait_wr("busystart", 1, 100);
        n = 0;
        while (i2c_req && n < 50) begin
            @(negedge clk);
            n++;
        end
        pulse_start(8'hFF);
        repeat (3) @(negedge clk);
        pulse_start(8'hEE);
        chk("busystart_still_busy", 32'(busy), 32'd1);
        wait_idle("busystart", 1000);
        chk("busystart_writes", 32'(wr_cnt), 32'd7);
        chk("busystart_all_seen", 32'(exp_q.size()), 32'd0);
        chk("busystart_done", 32'(done_cnt), 32'd1);
        repeat (5) @(negedge clk);
        chk("busystart_stays_idle", 32'(busy), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/i2c_otp_sequencer.md
I2C_OTP_SEQUENCER -- requirements
Module: i2c_otp_sequencer

Interface
REQ-001 Parameter DEV_ADDR, default 7'h0A, SHALL be the I2C device address driven on every transaction.
REQ-002 Parameter PASS_BASE, default 8'h05, SHALL be the first passcode register address.
REQ-003 Parameter CMD_REG, default 8'h04, SHALL be the OTP command register address.
REQ-004 Parameter GAP_CYC, default 16, SHALL be the idle clk cycles between transactions (range 1..255).
REQ-005 Parameter MAX_RETRY, default 3, SHALL be the NACKed attempts per byte before error (range 1..7).
REQ-006 Parameter TMO_CYC, default 1023, SHALL be the clk cycles to wait for i2c_done before timeout.
REQ-007 Clock and reset SHALL be one clock and a synchronous, active-high reset, named as follows.
REQ-008 clk  in  1  sole clock, all logic on rising edge.
REQ-009 rst  in  1  synchronous active-high reset.
REQ-010 start  in  1  one-cycle request to run the unlock+command sequence.
REQ-011 op  in  8  OTP command byte written to CMD_REG.
REQ-012 busy  out  1  high from the cycle after start is accepted until return to IDLE.
REQ-013 done  out  1  one-cycle pulse on successful completion.
REQ-014 err  out  1  sticky failure flag.
REQ-015 err_code  out  2  00 none, 01 NACK limit, 10 timeout.
REQ-016 i2c_req  out  1  write request to the I2C master engine.
REQ-017 i2c_dev  out  7  device address (always DEV_ADDR).
REQ-018 i2c_reg  out  8  target register address.
REQ-019 i2c_data  out  8  byte to write.
REQ-020 i2c_done  in  1  one-cycle pulse from the engine when the transaction ends.
REQ-021 i2c_nack  in  1  slave NACKed, valid only while i2c_done is high.

Function
REQ-022 States SHALL be IDLE, ISSUE, WAIT, GAP, DONE and ERR.
REQ-023 In IDLE, start=1 SHALL latch op, clear err/err_code, clear idx and retry count, and go to ISSUE. start SHALL be ignored in all other states.
REQ-024 The sequence index idx SHALL run 0..6.
  - idx 0..5: reg = PASS_BASE+idx; data = 8'h50, 48, 53, 47, 4E, 58 ("PHSGNX").
  - idx 6: reg = CMD_REG; data = latched op.
REQ-025 ISSUE SHALL assert i2c_req with stable reg/data, go to WAIT, and clear the timeout counter.
REQ-026 First i2c_req SHALL be high exactly 2 cycles after the cycle start is sampled.
REQ-027 WAIT SHALL hold i2c_req, reg and data stable until i2c_done.
REQ-028 i2c_req SHALL drop on the edge that samples i2c_done.
REQ-029 On i2c_done with i2c_nack=0, the retry count SHALL clear. If idx==6, go to DONE; else idx+1 and go to GAP.
REQ-030 On i2c_done with i2c_nack=1, the retry count SHALL increment.
  - If it reaches MAX_RETRY: err_code=01, go to ERR.
  - Else go to GAP and reissue the same idx.
REQ-031 In WAIT, a timeout counter reaching TMO_CYC without i2c_done SHALL set err_code=10, drop i2c_req and go to ERR. i2c_done in that same cycle SHALL take priority over the timeout.
REQ-032 GAP SHALL hold i2c_req low for exactly GAP_CYC cycles, then enter ISSUE.
REQ-033 DONE SHALL pulse done for one cycle and return to IDLE.
REQ-034 ERR SHALL set err for one cycle and return to IDLE. err and err_code SHALL hold until the next accepted start or reset.
REQ-035 i2c_done arriving outside WAIT SHALL be ignored.
REQ-036 Counters SHALL saturate, never wrap. idx SHALL never exceed 6.

Reset
REQ-037 rst=1 SHALL force IDLE and zero every output, counter, idx and latched op on the next edge, including mid-transaction. No done pulse SHALL be produced.

Structure
REQ-038 Package otp_i2c_pkg SHALL hold the state enum, the passcode byte array, the PASS_BASE/CMD_REG defaults and the err_code constants.
REQ-039 The block SHALL be a single module with no sub-module; timers are inline counters.

Verification
REQ-040 Bench SHALL check a clean run: start with op=8'hA5, engine acks each request 10 cycles later. Required: 7 writes (05:50, 06:48, 07:53, 08:47, 09:4E, 0A:58, 04:A5), each gap 16 cycles, one done pulse, err=0.
REQ-041 Bench SHALL check a single NACK: NACK the first attempt at idx 3. Required: reg 08 reissued after a 16-cycle gap, sequence completes, done=1.
REQ-042 Bench SHALL check the NACK limit: NACK idx 0 three times. Required: err=1, err_code=01, no done, i2c_req low, busy low.
REQ-043 Bench SHALL check timeout: never return i2c_done. Required: err_code=10 after 1023 WAIT cycles, i2c_req low.
REQ-044 Bench SHALL check reset mid-sequence: rst during WAIT at idx 4. Required: all outputs 0 the next cycle; a new start runs from idx 0.
REQ-045 Bench SHALL check start while busy: extra start pulses during GAP. Required: ignored, exactly 7 writes and one done.
